// File: rtl/memory_slave_model.sv
// memory_slave_model: word-addressed RAM slave with programmable read/write latency and a
// four-phase completion handshake.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous active-low reset
//   address          word address from master (low log2(SIZE_IN_WORDS) bits index the array)
//   dataOut          write data from master
//   writeEnabled     write request (wins over readEnabled when both are high)
//   readEnabled      read request
//   dataIn           read data to master, holds the last read value
//   functionComplete high in DONE until the master drops its enable
//
// Optional feature: define MEMORY_SLAVE_OUT_OF_RANGE_EN to treat any set address bit at or above
// log2(SIZE_IN_WORDS) as out of range (write discarded, read returns all ones). Without it the
// upper address bits are ignored and addresses wrap.
module memory_slave_model #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned SIZE_IN_WORDS = 256,
   parameter int unsigned READ_DELAY    = 2,
   parameter int unsigned WRITE_DELAY   = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0]    dataOut,
   input  logic                     writeEnabled,
   input  logic                     readEnabled,
   output logic [DATA_WIDTH-1:0]    dataIn,
   output logic                     functionComplete
);

   localparam int unsigned IDX_W     = $clog2(SIZE_IN_WORDS);
   localparam int unsigned MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
   localparam int unsigned CNT_W     = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t                state;
   logic                  op_write;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] wdata;
   logic [CNT_W-1:0]      cnt;
   logic                  req_active;
   logic                  mem_we;

   logic [DATA_WIDTH-1:0] mem [SIZE_IN_WORDS];

`ifdef MEMORY_SLAVE_OUT_OF_RANGE_EN
   logic oor;
   logic addr_oor;
   assign addr_oor = |(address >> IDX_W);
`else
   logic unused_addr;
   assign unused_addr = ^address;
`endif

   // The enable that started the operation must stay high, otherwise the access is aborted.
   assign req_active = op_write ? writeEnabled : readEnabled;

   always_comb begin
      mem_we = (state == StBusy) && op_write && req_active && (cnt == '0);
`ifdef MEMORY_SLAVE_OUT_OF_RANGE_EN
      if (oor) mem_we = 1'b0;
`endif
   end

   // Array has no reset so prior contents survive a reset.
   always_ff @(posedge clock) begin
      if (mem_we) mem[idx] <= wdata;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= StIdle;
         functionComplete <= 1'b0;
         dataIn           <= '0;
         cnt              <= '0;
         op_write         <= 1'b0;
         idx              <= '0;
         wdata            <= '0;
`ifdef MEMORY_SLAVE_OUT_OF_RANGE_EN
         oor              <= 1'b0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (writeEnabled) begin
                  op_write <= 1'b1;
                  idx      <= address[IDX_W-1:0];
                  wdata    <= dataOut;
                  cnt      <= CNT_W'(WRITE_DELAY);
                  state    <= StBusy;
`ifdef MEMORY_SLAVE_OUT_OF_RANGE_EN
                  oor      <= addr_oor;
`endif
               end else if (readEnabled) begin
                  op_write <= 1'b0;
                  idx      <= address[IDX_W-1:0];
                  cnt      <= CNT_W'(READ_DELAY);
                  state    <= StBusy;
`ifdef MEMORY_SLAVE_OUT_OF_RANGE_EN
                  oor      <= addr_oor;
`endif
               end
            end
            StBusy: begin
               if (!req_active) begin
                  state <= StIdle;
               end else if (cnt == '0) begin
                  if (!op_write) begin
`ifdef MEMORY_SLAVE_OUT_OF_RANGE_EN
                     dataIn <= oor ? '1 : mem[idx];
`else
                     dataIn <= mem[idx];
`endif
                  end
                  state <= StDone;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StDone: begin
               // functionComplete rises one edge after entering DONE, giving DELAY+2 latency.
               if (!writeEnabled && !readEnabled) begin
                  state            <= StIdle;
                  functionComplete <= 1'b0;
               end else begin
                  functionComplete <= 1'b1;
               end
            end
            default: begin
               state            <= StIdle;
               functionComplete <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_slave_model.sv
// tb_memory_slave_model: directed, table-driven bench for memory_slave_model. Drives a
// DELAY=2 instance and a DELAY=0 instance from one clock and reset.
module tb_memory_slave_model;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [31:0] addr, wdata, rdata;
   logic        we, re, fc;
   logic [31:0] zaddr, zwdata, zrdata;
   logic        zwe, zre, zfc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tab[8];
   vec_t ztab[8];

`ifdef MEMORY_SLAVE_OUT_OF_RANGE_EN
   localparam logic [31:0] EXP_WRAP_LO = 32'h11111111;
   localparam logic [31:0] EXP_WRAP_HI = 32'hFFFFFFFF;
`else
   localparam logic [31:0] EXP_WRAP_LO = 32'hA5A5A5A5;
   localparam logic [31:0] EXP_WRAP_HI = 32'hA5A5A5A5;
`endif

   always #5 clk = ~clk;

   memory_slave_model #(
      .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SIZE_IN_WORDS(256),
      .READ_DELAY(2), .WRITE_DELAY(2)
   ) dut (
      .clock(clk), .reset(rst_n), .address(addr), .dataOut(wdata),
      .writeEnabled(we), .readEnabled(re), .dataIn(rdata), .functionComplete(fc)
   );

   memory_slave_model #(
      .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SIZE_IN_WORDS(256),
      .READ_DELAY(0), .WRITE_DELAY(0)
   ) dut0 (
      .clock(clk), .reset(rst_n), .address(zaddr), .dataOut(zwdata),
      .writeEnabled(zwe), .readEnabled(zre), .dataIn(zrdata), .functionComplete(zfc)
   );

   task automatic check(input string name, input int id, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h expected %h", name, id, got, exp);
      end
   endtask

   function automatic logic cur_fc(input bit z);
      return z ? zfc : fc;
   endfunction

   function automatic logic [31:0] cur_rd(input bit z);
      return z ? zrdata : rdata;
   endfunction

   task automatic drive(input bit z, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d);
      if (z) begin
         zwe = w; zre = r; zaddr = a; zwdata = d;
      end else begin
         we = w; re = r; addr = a; wdata = d;
      end
   endtask

   // Called #1 after a rising edge. Returns #1 after the edge that takes the slave back to IDLE.
   task automatic do_op(input bit z, input vec_t v, input int id, input int hold);
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      drive(z, v.we, v.re, v.addr, v.wdata);
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (cur_fc(z)) seen = 1'b1;
      end
      check(z ? "z_complete" : "complete", id, {31'b0, seen}, 32'd1);
      check(z ? "z_latency" : "latency", id, n - 1, v.lat);
      check(z ? "z_data" : "data", id, cur_rd(z), v.exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("fc_hold", id, {31'b0, cur_fc(z)}, 32'd1);
      end
      drive(z, 1'b0, 1'b0, v.addr, v.wdata);
      @(posedge clk); #1;
      check(z ? "z_fc_drop" : "fc_drop", id, {31'b0, cur_fc(z)}, 32'd0);
   endtask

   initial begin
      vec_t v;
      bit   seen_fc;

      //          we    re    addr          wdata          exp           lat
      tab[0] = '{1'b1, 1'b0, 32'h0000_0003, 32'hCAFEF00D, 32'h11111111, 4};
      tab[1] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0,        32'hCAFEF00D, 4};
      tab[2] = '{1'b1, 1'b0, 32'h0000_0105, 32'hA5A5A5A5, 32'hCAFEF00D, 4};
      tab[3] = '{1'b0, 1'b1, 32'h0000_0005, 32'h0,        EXP_WRAP_LO,  4};
      tab[4] = '{1'b0, 1'b1, 32'h0000_0105, 32'h0,        EXP_WRAP_HI,  4};
      tab[5] = '{1'b1, 1'b1, 32'h0000_0007, 32'h00000042, EXP_WRAP_HI,  4};
      tab[6] = '{1'b0, 1'b1, 32'h0000_0007, 32'h0,        32'h00000042, 4};
      tab[7] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0,        32'hCAFEF00D, 4};

      ztab[0] = '{1'b1, 1'b0, 32'd10, 32'h00000001, 32'h00000000, 2};
      ztab[1] = '{1'b0, 1'b1, 32'd10, 32'h0,        32'h00000001, 2};
      ztab[2] = '{1'b1, 1'b0, 32'd11, 32'h00000022, 32'h00000001, 2};
      ztab[3] = '{1'b1, 1'b0, 32'd10, 32'h00000333, 32'h00000001, 2};
      ztab[4] = '{1'b0, 1'b1, 32'd11, 32'h0,        32'h00000022, 2};
      ztab[5] = '{1'b0, 1'b1, 32'd10, 32'h0,        32'h00000333, 2};
      ztab[6] = '{1'b1, 1'b0, 32'd12, 32'h00004444, 32'h00000333, 2};
      ztab[7] = '{1'b0, 1'b1, 32'd12, 32'h0,        32'h00004444, 2};

      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_fc", 0, {31'b0, fc}, 32'd0);
      check("rst_data", 0, rdata, 32'h0);
      check("rst_zfc", 0, {31'b0, zfc}, 32'd0);
      check("rst_zdata", 0, zrdata, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Preload mem[5], then reset in the middle of a write to it.
      v = '{1'b1, 1'b0, 32'd5, 32'h11111111, 32'h0, 4};
      do_op(1'b0, v, 100, 0);
      drive(1'b0, 1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_fc", 101, {31'b0, fc}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'd5, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_mid_fc_hold", 101, {31'b0, fc}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      v = '{1'b0, 1'b1, 32'd5, 32'h0, 32'h11111111, 4};
      do_op(1'b0, v, 102, 0);

      for (int i = 0; i < 8; i++) do_op(1'b0, tab[i], i, 1);

      // Abort: drop readEnabled while BUSY; fc must never rise and dataIn stays put.
      seen_fc = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 32'd7, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'd7, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (fc) seen_fc = 1'b1;
      end
      check("abort_fc", 200, {31'b0, seen_fc}, 32'd0);
      check("abort_data", 200, rdata, 32'hCAFEF00D);
      v = '{1'b0, 1'b1, 32'd7, 32'h0, 32'h00000042, 4};
      do_op(1'b0, v, 201, 0);

      for (int i = 0; i < 8; i++) do_op(1'b1, ztab[i], i, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
